img2col_reader: RTL and testbench

IMG2COL_READER -- requirements
Module: img2col_reader

---
 rtl/img2col_pkg.sv | 41 ++++
 rtl/skid_fifo2.sv | 64 ++++++
 rtl/img2col_reader.sv | 232 +++++++++++++++++++++++
 tb/tb_img2col_reader.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/img2col_pkg.sv
// Shared types and geometry helpers for the img2col patch reader.
package img2col_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // Marker bits that travel through the output FIFO beside each element.
    typedef struct packed {
        logic col_last;
        logic last;
    } elem_flags_t;

    function automatic int unsigned out_dim(input int unsigned img,
                                            input int unsigned k,
                                            input int unsigned stride);
        return (img - k) / stride + 1;
    endfunction

    function automatic int unsigned patch_len(input int unsigned ch, input int unsigned k);
        return ch * k * k;
    endfunction

    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEF_IMG_H  = 8;
    localparam int unsigned DEF_IMG_W  = 8;
    localparam int unsigned DEF_CH     = 1;
    localparam int unsigned DEF_K      = 3;
    localparam int unsigned DEF_STRIDE = 1;

    localparam int unsigned OH    = out_dim(DEF_IMG_H, DEF_K, DEF_STRIDE);
    localparam int unsigned OW    = out_dim(DEF_IMG_W, DEF_K, DEF_STRIDE);
    localparam int unsigned PATCH = patch_len(DEF_CH, DEF_K);

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry output FIFO; entry 0 is always the head so the output comes straight from a flop.
module skid_fifo2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [1:0]       count_o
);

    logic [WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
    logic             v0_q, v0_d, v1_q, v1_d;
    logic             push, pop;

    assign in_ready_o  = !v1_q;
    assign out_valid_o = v0_q;
    assign out_data_o  = e0_q;
    assign count_o     = {v1_q, v0_q & ~v1_q};
    assign push        = in_valid_i && in_ready_o;
    assign pop         = v0_q && out_ready_i;

    always_comb begin
        e0_d = e0_q;
        e1_d = e1_q;
        v0_d = v0_q;
        v1_d = v1_q;
        if (pop && push) begin
            // push implies entry 1 is empty, so the new element becomes the head
            e0_d = in_data_i;
        end else if (pop) begin
            e0_d = e1_q;
            v0_d = v1_q;
            v1_d = 1'b0;
        end else if (push) begin
            if (v0_q) begin
                e1_d = in_data_i;
                v1_d = 1'b1;
            end else begin
                e0_d = in_data_i;
                v0_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q <= '0;
            e1_q <= '0;
            v0_q <= 1'b0;
            v1_q <= 1'b0;
        end else begin
            e0_q <= e0_d;
            e1_q <= e1_d;
            v0_q <= v0_d;
            v1_q <= v1_d;
        end
    end

endmodule

// File: rtl/img2col_reader.sv
// Streams im2col patches out of a tensor RAM; addresses are walked with adders only.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 10
`endif

module img2col_reader
    import img2col_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = `DATA_WIDTH,
    parameter int unsigned ADDR_SIZE  = `ADDR_SIZE,
    parameter int unsigned IMG_H      = DEF_IMG_H,
    parameter int unsigned IMG_W      = DEF_IMG_W,
    parameter int unsigned CH         = DEF_CH,
    parameter int unsigned K          = DEF_K,
    parameter int unsigned STRIDE     = DEF_STRIDE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  ram_ena,
    output logic                  ram_wea,
    output logic [ADDR_SIZE-1:0]  ram_addr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_col_last,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned OUT_H = out_dim(IMG_H, K, STRIDE);
    localparam int unsigned OUT_W = out_dim(IMG_W, K, STRIDE);
    localparam int unsigned KW    = cnt_w(K);
    localparam int unsigned CW    = cnt_w(CH);
    localparam int unsigned OHW   = cnt_w(OUT_H);
    localparam int unsigned OWW   = cnt_w(OUT_W);
    localparam int unsigned FW    = DATA_WIDTH + 2;

    localparam logic [ADDR_SIZE-1:0] A_ROW  = ADDR_SIZE'(IMG_W);
    localparam logic [ADDR_SIZE-1:0] A_CHAN = ADDR_SIZE'(IMG_H * IMG_W);
    localparam logic [ADDR_SIZE-1:0] A_STEP = ADDR_SIZE'(STRIDE);
    localparam logic [ADDR_SIZE-1:0] A_OROW = ADDR_SIZE'(STRIDE * IMG_W);

    state_e               state_q, state_d;
    logic [KW-1:0]        kx_q, kx_d, ky_q, ky_d;
    logic [CW-1:0]        c_q, c_d;
    logic [OWW-1:0]       ox_q, ox_d;
    logic [OHW-1:0]       oy_q, oy_d;
    // Nested base addresses: output row, patch origin, channel plane, kernel row, element.
    logic [ADDR_SIZE-1:0] orow_q, orow_d, patch_q, patch_d, chan_q, chan_d;
    logic [ADDR_SIZE-1:0] row_q, row_d, addr_q, addr_d, base_nxt;
    logic                 rd_vld_q, rd_vld_d;
    elem_flags_t          rd_flags_q, rd_flags_d;
    logic                 busy_q, busy_d, done_q, done_d;

    logic                 issue, pop, col_end, pass_end;
    logic [2:0]           occ;
    logic                 fifo_in_ready;
    logic [1:0]           fifo_count;
    logic [FW-1:0]        fifo_out;

    assign col_end  = (kx_q == KW'(K - 1)) && (ky_q == KW'(K - 1)) && (c_q == CW'(CH - 1));
    assign pass_end = col_end && (ox_q == OWW'(OUT_W - 1)) && (oy_q == OHW'(OUT_H - 1));
    assign pop      = m_valid && m_ready;
    assign occ      = 3'(fifo_count) + 3'(rd_vld_q) - 3'(pop);
    assign issue    = (state_q == ST_RUN) && (occ < 3'd2);

    assign ram_ena  = issue;
    assign ram_wea  = 1'b0;
    assign ram_addr = addr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign {m_data, m_col_last, m_last} = fifo_out;

    always_comb begin
        if (rd_vld_q) begin
            assert (fifo_in_ready);
        end
    end

    always_comb begin
        state_d    = state_q;
        kx_d       = kx_q;
        ky_d       = ky_q;
        c_d        = c_q;
        ox_d       = ox_q;
        oy_d       = oy_q;
        orow_d     = orow_q;
        patch_d    = patch_q;
        chan_d     = chan_q;
        row_d      = row_q;
        addr_d     = addr_q;
        base_nxt   = '0;
        rd_vld_d   = issue;
        rd_flags_d = '{col_last: col_end, last: pass_end};

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    kx_d    = '0;
                    ky_d    = '0;
                    c_d     = '0;
                    ox_d    = '0;
                    oy_d    = '0;
                    orow_d  = '0;
                    patch_d = '0;
                    chan_d  = '0;
                    row_d   = '0;
                    addr_d  = '0;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    if (pass_end) begin
                        state_d = ST_DRAIN;
                    end
                    if (kx_q != KW'(K - 1)) begin
                        kx_d   = kx_q + KW'(1);
                        addr_d = addr_q + ADDR_SIZE'(1);
                    end else if (ky_q != KW'(K - 1)) begin
                        kx_d     = '0;
                        ky_d     = ky_q + KW'(1);
                        base_nxt = row_q + A_ROW;
                        row_d    = base_nxt;
                        addr_d   = base_nxt;
                    end else if (c_q != CW'(CH - 1)) begin
                        kx_d     = '0;
                        ky_d     = '0;
                        c_d      = c_q + CW'(1);
                        base_nxt = chan_q + A_CHAN;
                        chan_d   = base_nxt;
                        row_d    = base_nxt;
                        addr_d   = base_nxt;
                    end else if (ox_q != OWW'(OUT_W - 1)) begin
                        kx_d     = '0;
                        ky_d     = '0;
                        c_d      = '0;
                        ox_d     = ox_q + OWW'(1);
                        base_nxt = patch_q + A_STEP;
                        patch_d  = base_nxt;
                        chan_d   = base_nxt;
                        row_d    = base_nxt;
                        addr_d   = base_nxt;
                    end else begin
                        kx_d     = '0;
                        ky_d     = '0;
                        c_d      = '0;
                        ox_d     = '0;
                        oy_d     = oy_q + OHW'(1);
                        base_nxt = orow_q + A_OROW;
                        orow_d   = base_nxt;
                        patch_d  = base_nxt;
                        chan_d   = base_nxt;
                        row_d    = base_nxt;
                        addr_d   = base_nxt;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && m_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            kx_q       <= '0;
            ky_q       <= '0;
            c_q        <= '0;
            ox_q       <= '0;
            oy_q       <= '0;
            orow_q     <= '0;
            patch_q    <= '0;
            chan_q     <= '0;
            row_q      <= '0;
            addr_q     <= '0;
            rd_vld_q   <= 1'b0;
            rd_flags_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            kx_q       <= kx_d;
            ky_q       <= ky_d;
            c_q        <= c_d;
            ox_q       <= ox_d;
            oy_q       <= oy_d;
            orow_q     <= orow_d;
            patch_q    <= patch_d;
            chan_q     <= chan_d;
            row_q      <= row_d;
            addr_q     <= addr_d;
            rd_vld_q   <= rd_vld_d;
            rd_flags_q <= rd_flags_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    skid_fifo2 #(
        .WIDTH(FW)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (rd_vld_q),
        .in_ready_o (fifo_in_ready),
        .in_data_i  ({ram_dout, rd_flags_q}),
        .out_valid_o(m_valid),
        .out_ready_i(m_ready),
        .out_data_o (fifo_out),
        .count_o    (fifo_count)
    );

endmodule

// File: tb/tb_img2col_reader.sv
// Bench for img2col_reader: three geometries, 1-cycle RAM holding mem[i]=i, spec-level reference stream.
module tb_img2col_reader;

    localparam int unsigned DW   = 16;
    localparam int unsigned AW   = 10;
    localparam int unsigned ND   = 3;
    localparam int unsigned MAXE = 64;
    localparam int unsigned KK   = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic          start      [ND];
    logic          ram_ena    [ND];
    logic          ram_wea    [ND];
    logic [AW-1:0] ram_addr   [ND];
    logic [DW-1:0] ram_dout   [ND];
    logic          m_valid    [ND];
    logic          m_ready    [ND];
    logic [DW-1:0] m_data     [ND];
    logic          m_col_last [ND];
    logic          m_last     [ND];
    logic          busy       [ND];
    logic          done       [ND];

    int cfg_hw [ND] = '{4, 5, 3};
    int cfg_ch [ND] = '{1, 1, 2};
    int cfg_s  [ND] = '{1, 2, 1};

    int unsigned   exp_val [ND][MAXE];
    bit            exp_col [ND][MAXE];
    bit            exp_lst [ND][MAXE];
    int            exp_n   [ND];
    logic [DW-1:0] got     [ND][MAXE];

    int checks = 0;
    int errors = 0;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int unsigned GHW = (g == 0) ? 4 : (g == 1) ? 5 : 3;
        localparam int unsigned GCH = (g == 2) ? 2 : 1;
        localparam int unsigned GS  = (g == 1) ? 2 : 1;

        img2col_reader #(
            .DATA_WIDTH(DW), .ADDR_SIZE(AW), .IMG_H(GHW), .IMG_W(GHW),
            .CH(GCH), .K(KK), .STRIDE(GS)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start[g]),
            .ram_ena   (ram_ena[g]),
            .ram_wea   (ram_wea[g]),
            .ram_addr  (ram_addr[g]),
            .ram_dout  (ram_dout[g]),
            .m_valid   (m_valid[g]),
            .m_ready   (m_ready[g]),
            .m_data    (m_data[g]),
            .m_col_last(m_col_last[g]),
            .m_last    (m_last[g]),
            .busy      (busy[g]),
            .done      (done[g])
        );

        always @(posedge clk) begin
            if (ram_ena[g]) ram_dout[g] <= DW'(ram_addr[g]);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference stream straight from the loop order and address formula.
    task automatic build_exp(input int d);
        int hw = cfg_hw[d];
        int ch = cfg_ch[d];
        int s  = cfg_s[d];
        int o  = (hw - int'(KK)) / s + 1;
        int n  = 0;
        for (int oy = 0; oy < o; oy++)
            for (int ox = 0; ox < o; ox++)
                for (int c = 0; c < ch; c++)
                    for (int ky = 0; ky < int'(KK); ky++)
                        for (int kx = 0; kx < int'(KK); kx++) begin
                            exp_val[d][n] = c * hw * hw + (oy * s + ky) * hw + ox * s + kx;
                            exp_col[d][n] = (c == ch - 1) && (ky == int'(KK) - 1) && (kx == int'(KK) - 1);
                            exp_lst[d][n] = exp_col[d][n] && (oy == o - 1) && (ox == o - 1);
                            n++;
                        end
        exp_n[d] = n;
    endtask

    function automatic logic [63:0] outs_vec(input int d);
        return 64'({ram_ena[d], ram_wea[d], ram_addr[d], m_valid[d], m_data[d],
                    m_col_last[d], m_last[d], busy[d], done[d]});
    endfunction

    task automatic run_pass(input int d, input int rdy_pct, input bit restart_mid, input int abort_at);
        int            idx       = 0;
        int            cyc       = 0;
        int            dones     = 0;
        bit            stalled   = 1'b0;
        bit            restarted = 1'b0;
        logic [DW-1:0] pd        = '0;
        logic          pc        = 1'b0;
        logic          pl        = 1'b0;

        start[d] = 1'b1;
        @(negedge clk);
        start[d] = 1'b0;
        chk($sformatf("busy_after_start_d%0d", d), 64'(busy[d]), 64'd1);

        while (cyc < 3000 && dones == 0) begin
            m_ready[d] = ($urandom_range(99) < rdy_pct);
            if (done[d]) dones++;
            if (stalled)
                chk($sformatf("stall_hold_d%0d_e%0d", d, idx),
                    64'({m_data[d], m_col_last[d], m_last[d]}), 64'({pd, pc, pl}));
            if (m_valid[d] && m_ready[d]) begin
                if (idx < exp_n[d]) begin
                    chk($sformatf("data_d%0d_e%0d", d, idx), 64'(m_data[d]), 64'(exp_val[d][idx]));
                    chk($sformatf("col_last_d%0d_e%0d", d, idx), 64'(m_col_last[d]), 64'(exp_col[d][idx]));
                    chk($sformatf("last_d%0d_e%0d", d, idx), 64'(m_last[d]), 64'(exp_lst[d][idx]));
                    got[d][idx] = m_data[d];
                end else begin
                    chk($sformatf("extra_elem_d%0d", d), 64'(idx), 64'(exp_n[d]));
                end
                idx++;
            end
            stalled = m_valid[d] && !m_ready[d];
            pd = m_data[d];
            pc = m_col_last[d];
            pl = m_last[d];
            if (restart_mid && !restarted && idx >= 10) begin
                start[d]  = 1'b1;
                restarted = 1'b1;
            end else begin
                start[d] = 1'b0;
            end
            if (abort_at >= 0 && idx == abort_at) begin
                #2 rst_n = 1'b0;
                #1 chk($sformatf("abort_outs_d%0d", d), outs_vec(d), 64'd0);
                @(negedge clk);
                chk($sformatf("abort_hold_d%0d", d), outs_vec(d), 64'd0);
                rst_n      = 1'b1;
                start[d]   = 1'b0;
                m_ready[d] = 1'b0;
                return;
            end
            @(negedge clk);
            cyc++;
        end

        if (rdy_pct == 100)
            chk($sformatf("throughput_d%0d", d), 64'(cyc <= exp_n[d] + 6), 64'd1);
        repeat (4) begin
            @(negedge clk);
            if (done[d]) dones++;
        end
        chk($sformatf("elem_count_d%0d", d), 64'(idx), 64'(exp_n[d]));
        chk($sformatf("done_pulses_d%0d", d), 64'(dones), 64'd1);
        chk($sformatf("idle_after_d%0d", d), 64'({busy[d], m_valid[d], ram_ena[d]}), 64'd0);
        m_ready[d] = 1'b0;
    endtask

    initial begin
        int first_patch [9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
        int patch_start [4] = '{0, 2, 10, 12};

        rst_n = 1'b0;
        for (int d = 0; d < int'(ND); d++) begin
            start[d]   = 1'b0;
            m_ready[d] = 1'b0;
            build_exp(d);
        end
        repeat (2) @(negedge clk);
        for (int d = 0; d < int'(ND); d++)
            chk($sformatf("reset_outs_d%0d", d), outs_vec(d), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 4x4, K=3, stride 1, always ready
        run_pass(0, 100, 1'b0, -1);
        for (int i = 0; i < 9; i++)
            chk($sformatf("first_patch_e%0d", i), 64'(got[0][i]), 64'(first_patch[i]));
        chk("final_value", 64'(got[0][35]), 64'd15);

        // 5x5, stride 2
        run_pass(1, 100, 1'b0, -1);
        for (int p = 0; p < 4; p++)
            chk($sformatf("stride2_patch%0d_first", p), 64'(got[1][p * 9]), 64'(patch_start[p]));

        // two channels, single 18-element patch
        run_pass(2, 100, 1'b0, -1);
        for (int i = 0; i < 18; i++)
            chk($sformatf("two_chan_e%0d", i), 64'(got[2][i]), 64'(i));

        // random backpressure, then a stray start mid-pass
        run_pass(0, 50, 1'b0, -1);
        run_pass(0, 50, 1'b1, -1);

        // abort at element 20 and restart from scratch
        run_pass(0, 100, 1'b0, 20);
        @(negedge clk);
        run_pass(0, 60, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
